alu_ctrl: RTL

Sequencer that sits between instruction decode and the 6502 ALU. It accepts accumulator-class commands over a valid/ready handshake and drives the ALU's operand, opcode and carry inputs, running two passes where one is not enough. It owns the accumulator A and the N/V/Z/C status flags, and writes the ALU results and flags back into them.

---
 rtl/cpu6502_pkg.sv | 40 ++++
 rtl/status_flags.sv | 103 ++++++++++
 rtl/alu_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502 accumulator/ALU sequencer.
package cpu6502_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned ALU_OP_W = 5;

  // One-hot ALU operation selects.
  localparam logic [ALU_OP_W-1:0] ALU_OP_NONE = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUM  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_EOR  = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SR   = 5'b00001;

  // Accumulator-class commands; codes 14 and 15 are unused and act as NOP.
  typedef enum logic [CMD_W-1:0] {
    CMD_LDA = 4'd0,
    CMD_ADC = 4'd1,
    CMD_SBC = 4'd2,
    CMD_AND = 4'd3,
    CMD_ORA = 4'd4,
    CMD_EOR = 4'd5,
    CMD_CMP = 4'd6,
    CMD_ASL = 4'd7,
    CMD_ROL = 4'd8,
    CMD_LSR = 4'd9,
    CMD_ROR = 4'd10,
    CMD_CLC = 4'd11,
    CMD_SEC = 4'd12,
    CMD_CLV = 4'd13
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2
  } state_t;

endpackage

// File: rtl/status_flags.sv
// N/V/Z/C status register with per-command update masks.
// Ports: clk, rst_n (sync, active-low); upd_en strobes a retiring command;
// cmd selects which flags change; result/alu_overflow/alu_carry_out/shift_c
// are the candidate values; flag_n/v/z/c are the registered flags.
module status_flags
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [CMD_W-1:0] cmd,
  input  logic [WIDTH-1:0] result,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             shift_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_c
);

  logic flag_n_q, flag_v_q, flag_z_q, flag_c_q;
  logic flag_n_d, flag_v_d, flag_z_d, flag_c_d;
  logic upd_nz_c, upd_v_c, upd_c_c;
  logic v_val_c, c_val_c;

  // Which flags each command touches, and where V/C come from.
  always_comb begin
    upd_nz_c = 1'b0;
    upd_v_c  = 1'b0;
    upd_c_c  = 1'b0;
    v_val_c  = alu_overflow;
    c_val_c  = alu_carry_out;
    case (cmd)
      CMD_LDA, CMD_AND, CMD_ORA, CMD_EOR: upd_nz_c = 1'b1;
      CMD_ADC, CMD_SBC: begin
        upd_nz_c = 1'b1;
        upd_v_c  = 1'b1;
        upd_c_c  = 1'b1;
      end
      CMD_CMP, CMD_ASL, CMD_ROL: begin
        upd_nz_c = 1'b1;
        upd_c_c  = 1'b1;
      end
      CMD_LSR, CMD_ROR: begin
        upd_nz_c = 1'b1;
        upd_c_c  = 1'b1;
        c_val_c  = shift_c;
      end
      CMD_CLC: begin
        upd_c_c = 1'b1;
        c_val_c = 1'b0;
      end
      CMD_SEC: begin
        upd_c_c = 1'b1;
        c_val_c = 1'b1;
      end
      CMD_CLV: begin
        upd_v_c = 1'b1;
        v_val_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Next flag values.
  always_comb begin
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (upd_en) begin
      if (upd_nz_c) begin
        flag_n_d = result[WIDTH-1];
        flag_z_d = (result == '0);
      end
      if (upd_v_c) flag_v_d = v_val_c;
      if (upd_c_c) flag_c_d = c_val_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b1;
      flag_c_q <= 1'b0;
    end else begin
      flag_n_q <= flag_n_d;
      flag_v_q <= flag_v_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_n = flag_n_q;
  assign flag_v = flag_v_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer between instruction decode and the 6502 ALU: accepts
// accumulator commands on req_valid/req_ready, drives registered ALU
// operands/op/carry, owns A and the status flags, pulses done on retire.
// Ports: clk, rst_n (sync, active-low); req_* command handshake;
// alu_a/b/op/carry_in/decimal to the ALU; alu_result/overflow/carry_out
// back from it; acc, flag_n/v/z/c architectural state; done retire pulse.
module alu_ctrl
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CMD_W-1:0]    req_cmd,
  input  logic [WIDTH-1:0]    req_operand,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_carry_in,
  output logic                alu_decimal,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_overflow,
  input  logic                alu_carry_out,
  output logic [WIDTH-1:0]    acc,
  output logic                flag_n,
  output logic                flag_v,
  output logic                flag_z,
  output logic                flag_c,
  output logic                done
);

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [WIDTH-1:0]    operand_q, operand_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                c_new_q, c_new_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                alu_cin_q, alu_cin_d;

  logic                flag_upd_c;
  logic [WIDTH-1:0]    flag_res_c;
  logic                shift_c_c;

  // FSM next state, accumulator write-back and flag update strobe.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    c_new_d    = c_new_q;
    done_d     = 1'b0;
    flag_upd_c = 1'b0;
    flag_res_c = alu_result;
    shift_c_c  = acc_q[0];
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d     = req_cmd;
          operand_d = req_operand;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_q == CMD_ROR) begin
          // Remember the bit shifted out; C must keep its old value for pass 2.
          c_new_d = acc_q[0];
          state_d = ST_EXEC2;
        end else begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          flag_upd_c = 1'b1;
          case (cmd_q)
            CMD_LDA: begin
              acc_d      = operand_q;
              flag_res_c = operand_q;
            end
            CMD_ADC, CMD_SBC, CMD_AND, CMD_ORA, CMD_EOR,
            CMD_ASL, CMD_ROL, CMD_LSR: acc_d = alu_result;
            default: ;
          endcase
        end
      end
      ST_EXEC2: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        flag_upd_c = 1'b1;
        acc_d      = alu_result;
        shift_c_c  = c_new_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive for the cycle being entered; registered so the ALU sees stable inputs.
  always_comb begin
    alu_a_d   = acc_d;
    alu_b_d   = '0;
    alu_op_d  = ALU_OP_NONE;
    alu_cin_d = 1'b0;
    ready_d   = (state_d == ST_IDLE);
    case (state_d)
      ST_EXEC: begin
        case (cmd_d)
          CMD_ADC: begin
            alu_b_d   = operand_d;
            alu_op_d  = ALU_OP_SUM;
            alu_cin_d = flag_c;
          end
          CMD_SBC: begin
            alu_b_d   = ~operand_d;
            alu_op_d  = ALU_OP_SUM;
            alu_cin_d = flag_c;
          end
          CMD_CMP: begin
            alu_b_d   = ~operand_d;
            alu_op_d  = ALU_OP_SUM;
            alu_cin_d = 1'b1;
          end
          CMD_AND: begin
            alu_b_d  = operand_d;
            alu_op_d = ALU_OP_AND;
          end
          CMD_ORA: begin
            alu_b_d  = operand_d;
            alu_op_d = ALU_OP_OR;
          end
          CMD_EOR: begin
            alu_b_d  = operand_d;
            alu_op_d = ALU_OP_EOR;
          end
          CMD_ASL: begin
            alu_b_d  = acc_d;
            alu_op_d = ALU_OP_SUM;
          end
          CMD_ROL: begin
            alu_b_d   = acc_d;
            alu_op_d  = ALU_OP_SUM;
            alu_cin_d = flag_c;
          end
          CMD_LSR, CMD_ROR: alu_op_d = ALU_OP_SR;
          default: ;
        endcase
      end
      ST_EXEC2: begin
        // Pass 2 of ROR: OR old carry into bit 7 of the pass-1 shift result.
        alu_a_d  = alu_result;
        alu_b_d  = {flag_c, (WIDTH-1)'(0)};
        alu_op_d = ALU_OP_OR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      c_new_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= ALU_OP_NONE;
      alu_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      c_new_q   <= c_new_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
    end
  end

  status_flags #(
    .WIDTH(WIDTH)
  ) u_status_flags (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd_en       (flag_upd_c),
    .cmd          (cmd_q),
    .result       (flag_res_c),
    .alu_overflow (alu_overflow),
    .alu_carry_out(alu_carry_out),
    .shift_c      (shift_c_c),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  assign req_ready    = ready_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_carry_in = alu_cin_q;
  assign alu_decimal  = 1'b0;
  assign acc          = acc_q;
  assign done         = done_q;

endmodule
